// File: rtl/autocal_pkg.sv
// Shared constants and payload types for the offset auto-calibration block.
// Holds the FSM state encodings and the calibration register map.
package autocal_pkg;

  localparam int unsigned STATE_W    = 3;
  localparam int unsigned CAL_ADDR_W = 3;
  localparam int unsigned CAL_DATA_W = 16;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned LOG2_W     = 4;

  localparam logic [STATE_W-1:0] ST_IDLE       = 3'd0;
  localparam logic [STATE_W-1:0] ST_CLEAR      = 3'd1;
  localparam logic [STATE_W-1:0] ST_SETTLE     = 3'd2;
  localparam logic [STATE_W-1:0] ST_ACCUMULATE = 3'd3;
  localparam logic [STATE_W-1:0] ST_COMPUTE    = 3'd4;
  localparam logic [STATE_W-1:0] ST_WRITE      = 3'd5;
  localparam logic [STATE_W-1:0] ST_FLUSH      = 3'd6;

  localparam logic [CAL_ADDR_W-1:0] CAL_ADDR_OFFSET = 3'd1;

  // One calibration register write beat.
  typedef struct packed {
    logic                  we;
    logic [CAL_ADDR_W-1:0] addr;
    logic [CAL_DATA_W-1:0] data;
  } cal_wr_t;

  localparam cal_wr_t CAL_WR_IDLE = '{we: 1'b0, addr: '0, data: '0};

endpackage

// File: rtl/autocal_accumulator.sv
// Signed sample accumulator with floor-mean and negate-and-saturate to 16 bits.
// The offset output is combinational and only meaningful once accumulation is complete.
module autocal_accumulator
  import autocal_pkg::*;
#(
  parameter int unsigned DATA_PATH_WIDTH  = 16,
  parameter int unsigned MAX_LOG2_SAMPLES = 12
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              clear,
  input  logic                              add,
  input  logic signed [DATA_PATH_WIDTH-1:0] sample,
  input  logic        [LOG2_W-1:0]          shift,
  output logic signed [CAL_DATA_W-1:0]      offset_c
);

  localparam int unsigned ACC_W = DATA_PATH_WIDTH + MAX_LOG2_SAMPLES + 1;
  localparam int unsigned EXT_W = ACC_W - DATA_PATH_WIDTH;

  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W + 1)'(32767);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W + 1)'(-32768);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sample_ext_c;
  logic signed [ACC_W-1:0] mean_c;
  logic signed [ACC_W:0]   mean_ext_c;
  logic signed [ACC_W:0]   neg_c;

  assign sample_ext_c = {{EXT_W{sample[DATA_PATH_WIDTH-1]}}, sample};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (add) begin
      acc <= acc + sample_ext_c;
    end
  end

  // Arithmetic shift gives the floor of the mean; one extra bit keeps the negation exact.
  always_comb begin
    mean_c     = acc >>> shift;
    mean_ext_c = {mean_c[ACC_W-1], mean_c};
    neg_c      = -mean_ext_c;
    if (neg_c > SAT_MAX) begin
      offset_c = 16'sh7FFF;
    end else if (neg_c < SAT_MIN) begin
      offset_c = -16'sh7FFF - 16'sh0001;
    end else begin
      offset_c = neg_c[CAL_DATA_W-1:0];
    end
  end

endmodule

// File: rtl/offset_autocal.sv
// Offset auto-calibration controller: clears the offset register, settles, averages
// 2^k samples, writes back the negated mean, then pulses a downstream flush.
module offset_autocal
  import autocal_pkg::*;
#(
  parameter int unsigned DATA_PATH_WIDTH  = 16,
  parameter int unsigned MAX_LOG2_SAMPLES = 12
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              abort,
  input  logic        [CNT_W-1:0]           settle_samples,
  input  logic        [LOG2_W-1:0]          log2_samples,
  input  logic signed [DATA_PATH_WIDTH-1:0] data_in,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic        [CAL_ADDR_W-1:0]      cal_address,
  output logic        [CAL_DATA_W-1:0]      cal_data,
  output logic                              cal_we,
  output logic                              pipeline_flush,
  output logic                              busy,
  output logic                              done,
  output logic        [CAL_DATA_W-1:0]      offset_result
);

  localparam logic [LOG2_W-1:0] LOG2_CAP = LOG2_W'(MAX_LOG2_SAMPLES);

  logic [STATE_W-1:0]    state, state_nxt;
  logic [CNT_W-1:0]      settle_lat, settle_lat_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [LOG2_W-1:0]     log2_lat, log2_lat_nxt;
  cal_wr_t               cal_wr, cal_wr_nxt;
  logic                  flush_nxt;
  logic                  busy_nxt;
  logic                  done_nxt;
  logic [CAL_DATA_W-1:0] offset_result_nxt;

  logic                         acc_clear_c;
  logic                         acc_add_c;
  logic [LOG2_W-1:0]            log2_clamped_c;
  logic [CNT_W-1:0]             n_last_c;
  logic signed [CAL_DATA_W-1:0] offset_c;

  assign log2_clamped_c = (log2_samples > LOG2_CAP) ? LOG2_CAP : log2_samples;
  assign n_last_c       = CNT_W'((32'd1 << log2_lat) - 32'd1);

  autocal_accumulator #(
    .DATA_PATH_WIDTH (DATA_PATH_WIDTH),
    .MAX_LOG2_SAMPLES(MAX_LOG2_SAMPLES)
  ) u_accumulator (
    .clock   (clock),
    .reset   (reset),
    .clear   (acc_clear_c),
    .add     (acc_add_c),
    .sample  (data_in),
    .shift   (log2_lat),
    .offset_c(offset_c)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      settle_lat     <= '0;
      cnt            <= '0;
      log2_lat       <= '0;
      cal_wr         <= CAL_WR_IDLE;
      pipeline_flush <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      offset_result  <= '0;
      in_ready       <= 1'b0;
    end else begin
      state          <= state_nxt;
      settle_lat     <= settle_lat_nxt;
      cnt            <= cnt_nxt;
      log2_lat       <= log2_lat_nxt;
      cal_wr         <= cal_wr_nxt;
      pipeline_flush <= flush_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      offset_result  <= offset_result_nxt;
      in_ready       <= 1'b1;
    end
  end

  // Registered outputs are loaded from the upcoming state so they line up with it.
  always_comb begin
    state_nxt         = state;
    settle_lat_nxt    = settle_lat;
    cnt_nxt           = cnt;
    log2_lat_nxt      = log2_lat;
    cal_wr_nxt        = CAL_WR_IDLE;
    flush_nxt         = 1'b0;
    done_nxt          = done;
    offset_result_nxt = offset_result;
    acc_clear_c       = 1'b0;
    acc_add_c         = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt      = ST_CLEAR;
          settle_lat_nxt = settle_samples;
          log2_lat_nxt   = log2_clamped_c;
          cnt_nxt        = '0;
          done_nxt       = 1'b0;
          acc_clear_c    = 1'b1;
          cal_wr_nxt     = '{we: 1'b1, addr: CAL_ADDR_OFFSET, data: '0};
        end
      end
      ST_CLEAR: begin
        state_nxt = abort ? ST_IDLE : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (settle_lat == '0) begin
          state_nxt = ST_ACCUMULATE;
          cnt_nxt   = '0;
        end else if (in_valid) begin
          if (cnt == settle_lat - 16'd1) begin
            state_nxt = ST_ACCUMULATE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
      end
      ST_ACCUMULATE: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (in_valid) begin
          acc_add_c = 1'b1;
          if (cnt == n_last_c) begin
            state_nxt = ST_COMPUTE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
      end
      ST_COMPUTE: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt         = ST_WRITE;
          cal_wr_nxt        = '{we: 1'b1, addr: CAL_ADDR_OFFSET, data: offset_c};
          offset_result_nxt = offset_c;
        end
      end
      ST_WRITE: begin
        state_nxt = ST_FLUSH;
        flush_nxt = 1'b1;
      end
      ST_FLUSH: begin
        state_nxt = ST_IDLE;
        done_nxt  = 1'b1;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

  assign cal_we      = cal_wr.we;
  assign cal_address = cal_wr.addr;
  assign cal_data    = cal_wr.data;

endmodule

// File: doc/offset_autocal.md
OFFSET_AUTOCAL -- requirements
Module: offset_autocal

Interface
REQ-001 SHALL have parameter DATA_PATH_WIDTH, default 16, range 8..16: width of the sample input.
REQ-002 SHALL have parameter MAX_LOG2_SAMPLES, default 12: largest averaging exponent.
REQ-003 SHALL have port clock, input, 1: single clock for all logic.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: one-cycle request to begin a calibration run.
REQ-006 SHALL have port abort, input, 1: cancels a run in progress.
REQ-007 SHALL have port settle_samples, input, 16: number of valid samples discarded before averaging.
REQ-008 SHALL have port log2_samples, input, 4: averaging window exponent, N = 2^log2_samples.
REQ-009 SHALL have port data_in, input, DATA_PATH_WIDTH: signed raw ADC sample.
REQ-010 SHALL have port in_valid, input, 1: data_in qualifier.
REQ-011 SHALL have port in_ready, output, 1: sample acceptance; high whenever reset is deasserted.
REQ-012 SHALL have port cal_address, output, 3: calibration register address.
REQ-013 SHALL have port cal_data, output, 16: calibration register write data.
REQ-014 SHALL have port cal_we, output, 1: one-cycle calibration write strobe.
REQ-015 SHALL have port pipeline_flush, output, 1: one-cycle flush pulse to the downstream calibration stage.
REQ-016 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-017 SHALL have port done, output, 1: sticky completion flag.
REQ-018 SHALL have port offset_result, output, 16: last offset written.

Function
REQ-019 SHALL implement states IDLE, CLEAR, SETTLE, ACCUMULATE, COMPUTE, WRITE, FLUSH.
REQ-020 SHALL, on start in IDLE, latch settle_samples and min(log2_samples, MAX_LOG2_SAMPLES), clear done, and enter CLEAR; start outside IDLE SHALL be ignored.
REQ-021 SHALL, in CLEAR, assert cal_we for exactly one cycle with cal_address=1 and cal_data=0, then enter SETTLE.
REQ-022 SHALL, in SETTLE, discard exactly the latched number of samples with in_valid=1; a value of 0 SHALL cause ACCUMULATE on the next cycle.
REQ-023 SHALL, in ACCUMULATE, sum exactly N valid samples into a signed accumulator of DATA_PATH_WIDTH+MAX_LOG2_SAMPLES+1 bits; the cycle after the Nth sample SHALL be COMPUTE.
REQ-024 SHALL, in COMPUTE (1 cycle), form mean = accumulator arithmetically shifted right by log2_samples (floor), offset = -mean saturated to the signed 16-bit range, sign-extended to 16 bits.
REQ-025 SHALL, in WRITE (1 cycle), assert cal_we with cal_address=1 and cal_data=offset, and update offset_result.
REQ-026 SHALL, in FLUSH (1 cycle), assert pipeline_flush, then return to IDLE with done=1.
REQ-027 SHALL keep cal_we low and cal_address/cal_data at 0 outside the CLEAR and WRITE cycles.
REQ-028 SHALL, on abort in any state after IDLE except WRITE and FLUSH, return to IDLE next cycle with no further write and done=0; abort in WRITE or FLUSH SHALL be ignored.
REQ-029 SHALL give abort priority over in_valid in the same cycle.
REQ-030 SHALL produce a total run latency of 3 + settle + N valid samples + 2 cycles when in_valid is continuous.

Reset
REQ-031 SHALL, on reset low, asynchronously force IDLE, accumulator=0, counters=0, cal_we=0, cal_address=0, cal_data=0, pipeline_flush=0, busy=0, done=0, offset_result=0.
REQ-032 SHALL, on reset low mid-run, abandon the run with no write issued after reset deassertion.

Structure
REQ-033 SHALL take state encodings and the calibration address constants (OFFSET=1) from shared package autocal_pkg.
REQ-034 SHALL place the accumulate/shift/negate-saturate datapath in sub-module autocal_accumulator.

Verification
REQ-035 SHALL verify: data_in=100 constant, settle=2, log2=4 -> CLEAR write 0, then WRITE at address 1 with cal_data=0xFF9C, pipeline_flush pulse, done=1.
REQ-036 SHALL verify: data_in=-32768 constant, log2=3 -> cal_data=0x7FFF (saturated).
REQ-037 SHALL verify: alternating samples -3/-4, log2=1 -> mean=-4 (floor), cal_data=0x0004.
REQ-038 SHALL verify: in_valid gapped 1-in-3, log2=2 -> exactly 4 valid samples summed, timing per REQ-030 scaled.
REQ-039 SHALL verify: abort during ACCUMULATE -> busy=0 next cycle, no WRITE strobe, done=0; a new start then completes normally.
REQ-040 SHALL verify: reset asserted mid-SETTLE -> all outputs 0 immediately, no cal_we after release; log2=15 clamps to 12.
